// File: rtl/seg_value_formatter.sv
// seg_value_formatter: 16-bit value to four seven-segment digit patterns.
// Hex mode encodes the nibbles directly; decimal mode runs a 16-step
// shift-add-3 conversion, with optional leading-zero blanking and a dash
// display for values above 9999.
module seg_value_formatter #(
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        hex_mode,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [6:0]  digit0_segments,
  output logic [6:0]  digit1_segments,
  output logic [6:0]  digit2_segments,
  output logic [6:0]  digit3_segments
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    ENCODE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     shift_reg;
  logic [4:0]      step_cnt;
  logic            hex_q;
  logic            ovf_q;
  logic [3:0][6:0] enc_seg;

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // One double-dabble step: adjust each BCD nibble >= 5, then shift left.
  function automatic logic [31:0] dd_step(input logic [31:0] r);
    logic [31:0] t;
    t = r;
    for (int unsigned i = 0; i < 4; i++) begin
      if (t[16 + 4*i +: 4] >= 4'd5) begin
        t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[30:0], 1'b0};
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load) begin
          if (hex_mode || (value > 16'd9999)) begin
            state_next = ENCODE;
          end else begin
            state_next = CONVERT;
          end
        end
      end
      CONVERT: begin
        if (step_cnt == 5'd15) begin
          state_next = ENCODE;
        end
      end
      ENCODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Hex nibbles are latched into the same upper half that holds the BCD
  // result after conversion, so encoding always reads shift_reg[31:16].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg       <= '0;
      step_cnt        <= '0;
      hex_q           <= 1'b0;
      ovf_q           <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      digit0_segments <= '0;
      digit1_segments <= '0;
      digit2_segments <= '0;
      digit3_segments <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            hex_q <= hex_mode;
            if (hex_mode) begin
              shift_reg <= {value, 16'h0000};
              ovf_q     <= 1'b0;
            end else if (value > 16'd9999) begin
              shift_reg <= '0;
              ovf_q     <= 1'b1;
            end else begin
              shift_reg <= {16'h0000, value};
              step_cnt  <= '0;
              ovf_q     <= 1'b0;
            end
          end
        end
        CONVERT: begin
          shift_reg <= dd_step(shift_reg);
          step_cnt  <= step_cnt + 5'd1;
        end
        ENCODE: begin
          digit0_segments <= enc_seg[0];
          digit1_segments <= enc_seg[1];
          digit2_segments <= enc_seg[2];
          digit3_segments <= enc_seg[3];
          overflow        <= ovf_q;
          done            <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Digit encoding; scans from digit3 down so blanking stops at the first
  // non-zero digit, and digit0 always clears the blanking run.
  always_comb begin
    logic        lead;
    logic [3:0]  nib;
    int unsigned d;
    enc_seg = '0;
    lead    = (BLANK_LEADING != 0);
    for (int unsigned k = 0; k < 4; k++) begin
      d   = 3 - k;
      nib = shift_reg[16 + 4*d +: 4];
      if ((nib != 4'h0) || (d == 0)) begin
        lead = 1'b0;
      end
      if (hex_q) begin
        enc_seg[d] = seg_code(nib);
      end else if (ovf_q) begin
        enc_seg[d] = 7'h40;
      end else if (lead) begin
        enc_seg[d] = 7'h00;
      end else begin
        enc_seg[d] = seg_code(nib);
      end
    end
  end

  // Busy spans every non-idle state
  always_comb begin
    busy = (state != IDLE);
  end

endmodule
